// File: rtl/bp_update_ctrl.sv
// BTB update scheduler: queues resolved-branch feedback and drains it into the
// single BTB write port when IF is idle, plus a table-clear sweep after reset/flush.
module bp_update_ctrl #(
    parameter int IDX_BITS   = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  upd_valid_i,
    input  logic [31:0]           upd_pc_i,
    input  logic                  upd_taken_i,
    input  logic [31:0]           upd_target_i,
    input  logic                  lookup_active_i,
    input  logic                  flush_i,
    output logic                  tbl_we_o,
    output logic [IDX_BITS-1:0]   tbl_idx_o,
    output logic                  tbl_valid_o,
    output logic [29-IDX_BITS:0]  tbl_tag_o,
    output logic [31:0]           tbl_target_o,
    output logic                  init_busy_o,
    output logic                  pred_block_o,
    output logic [15:0]           drop_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]        FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [IDX_BITS-1:0]   LAST_IDX   = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_next;
    logic [IDX_BITS-1:0] sweep_idx;
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [PTR_W:0]      count;
    logic                push, pop, drop;
    logic                fifo_empty, fifo_full;

    // Only word-aligned instruction addresses matter; pc[1:0] is never stored.
    logic [29:0]         fifo_pc     [FIFO_DEPTH];
    logic                fifo_taken  [FIFO_DEPTH];
    logic [31:0]         fifo_target [FIFO_DEPTH];
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^upd_pc_i[1:0];
    assign fifo_empty     = (count == '0);
    assign fifo_full      = (count == FULL_COUNT);

    always_comb begin
        state_next   = state;
        tbl_we_o     = 1'b0;
        tbl_idx_o    = '0;
        tbl_valid_o  = 1'b0;
        tbl_tag_o    = '0;
        tbl_target_o = '0;
        push         = 1'b0;
        pop          = 1'b0;
        drop         = 1'b0;
        if (rst_i) begin
            state_next = INIT;
        end else if (flush_i) begin
            drop       = upd_valid_i;
            state_next = INIT;
        end else if (state == INIT) begin
            tbl_we_o  = 1'b1;
            tbl_idx_o = sweep_idx;
            drop      = upd_valid_i;
            if (sweep_idx == LAST_IDX) begin
                state_next = RUN;
            end
        end else begin
            push = upd_valid_i;
            // A full queue must drain now so the incoming push is never refused.
            if (!fifo_empty && (!lookup_active_i || fifo_full)) begin
                pop          = 1'b1;
                tbl_we_o     = 1'b1;
                tbl_idx_o    = fifo_pc[rd_ptr][IDX_BITS-1:0];
                tbl_tag_o    = fifo_pc[rd_ptr][29:IDX_BITS];
                tbl_valid_o  = fifo_taken[rd_ptr];
                tbl_target_o = fifo_target[rd_ptr];
            end
        end
    end

    assign init_busy_o  = rst_i || (state == INIT);
    assign pred_block_o = rst_i || (state == INIT) || (pop && lookup_active_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= INIT;
            sweep_idx  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            drop_cnt_o <= '0;
        end else begin
            state <= state_next;
            if (drop && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            if (flush_i) begin
                sweep_idx <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
            end else begin
                if (state == INIT) begin
                    sweep_idx <= sweep_idx + 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]     <= upd_pc_i[31:2];
            fifo_taken[wr_ptr]  <= upd_taken_i;
            fifo_target[wr_ptr] <= upd_target_i;
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the update scheduler.
module tb_bp_update_ctrl;
    localparam int IDX_BITS = 6;
    localparam int DEPTH    = 4;
    localparam int ENTRIES  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_req = 1'b1;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        lookup_active = 1'b0;
    logic        flush = 1'b0;

    wire         tbl_we;
    wire [5:0]   tbl_idx;
    wire         tbl_valid;
    wire [23:0]  tbl_tag;
    wire [31:0]  tbl_target;
    wire         init_busy;
    wire         pred_block;
    wire [15:0]  drop_cnt;

    bp_update_ctrl #(.IDX_BITS(IDX_BITS), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .upd_target_i(upd_target), .lookup_active_i(lookup_active), .flush_i(flush),
        .tbl_we_o(tbl_we), .tbl_idx_o(tbl_idx), .tbl_valid_o(tbl_valid),
        .tbl_tag_o(tbl_tag), .tbl_target_o(tbl_target),
        .init_busy_o(init_busy), .pred_block_o(pred_block), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_t;

    upd_t        q[$];
    bit          m_init = 1'b1;
    int          m_idx  = 0;
    int          m_drop = 0;
    logic [63:0] exp_vec;
    logic        exp_busy, exp_block;
    int          exp_drop;
    int          n_checks = 0;
    int          n_pass   = 0;

    wire [63:0]  act_vec = {tbl_we, tbl_idx, tbl_valid, tbl_tag, tbl_target};

    // Drives one cycle's inputs just after the edge, then at mid-cycle derives
    // the expected outputs from the model and advances the model past the edge.
    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic tk,
                                  input logic [31:0] tg, input logic la, input logic fl);
        upd_t e;
        @(posedge clk);
        #1;
        rst           = rst_req;
        upd_valid     = v;
        upd_pc        = pc;
        upd_taken     = tk;
        upd_target    = tg;
        lookup_active = la;
        flush         = fl;
        #4;
        exp_vec   = '0;
        exp_busy  = m_init;
        exp_block = 1'b0;
        exp_drop  = m_drop;
        if (rst) begin
            exp_busy  = 1'b1;
            exp_block = 1'b1;
            m_init    = 1'b1;
            m_idx     = 0;
            m_drop    = 0;
            q.delete();
        end else if (fl) begin
            exp_block = m_init;
            if (v && m_drop < 65535) m_drop++;
            q.delete();
            m_init = 1'b1;
            m_idx  = 0;
        end else if (m_init) begin
            exp_vec   = {1'b1, 6'(m_idx), 1'b0, 24'h0, 32'h0};
            exp_block = 1'b1;
            if (v && m_drop < 65535) m_drop++;
            m_idx++;
            if (m_idx == ENTRIES) m_init = 1'b0;
        end else begin
            if (q.size() > 0 && (!la || q.size() == DEPTH)) begin
                e         = q.pop_front();
                exp_vec   = {1'b1, e.pc[7:2], e.taken, e.pc[31:8], e.target};
                exp_block = la;
            end
            if (v) begin
                e.pc = pc; e.taken = tk; e.target = tg;
                q.push_back(e);
            end
        end
    endtask

    function automatic logic [31:0] rand_word();
        return $urandom();
    endfunction

    task automatic test_reset();
        rst_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), rand_word(), 1'b1, rand_word(),
                           1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if ({tbl_we, init_busy, pred_block} !== 3'b011)
                $display("[TB] FAIL reset_outputs[%0d] act=%b exp=011", i, {tbl_we, init_busy, pred_block});
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (drop_cnt !== 16'd0) $display("[TB] FAIL reset_drop act=%0d exp=0", drop_cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_init_sweep();
        rst_req = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), rand_word(), 1'b1, rand_word(),
                           1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if ({tbl_we, tbl_idx, tbl_valid, tbl_tag, tbl_target, init_busy, pred_block} !==
                {1'b1, 6'(i), 1'b0, 24'h0, 32'h0, 1'b1, 1'b1})
                $display("[TB] FAIL sweep[%0d] act=%h exp_idx=%0d busy=%b block=%b", i, act_vec, i, init_busy, pred_block);
            else n_pass++;
            n_checks++;
            if (drop_cnt !== 16'(exp_drop)) $display("[TB] FAIL sweep_drop act=%0d exp=%0d", drop_cnt, exp_drop);
            else n_pass++;
        end
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({init_busy, tbl_we, pred_block} !== 3'b000)
            $display("[TB] FAIL init_done act=%b exp=000", {init_busy, tbl_we, pred_block});
        else n_pass++;
    endtask

    task automatic test_single_update();
        apply_stimulus(1'b1, 32'h0000_1088, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
        n_checks++;
        if (tbl_we !== 1'b0) $display("[TB] FAIL no_bypass act=%b exp=0", tbl_we);
        else n_pass++;
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({act_vec, pred_block} !== {1'b1, 6'h22, 1'b1, 24'h000010, 32'h0000_2000, 1'b0})
            $display("[TB] FAIL single_write act=%h block=%b", act_vec, pred_block);
        else n_pass++;
    endtask

    task automatic test_lookup_hold();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i < 3, rand_word(), 1'($urandom_range(0, 1)), rand_word(), 1'b1, 1'b0);
            n_checks++;
            if (tbl_we !== 1'b0) $display("[TB] FAIL hold_no_write[%0d] act=%b exp=0", i, tbl_we);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            n_checks++;
            if ({act_vec, pred_block} !== {exp_vec, exp_block} || tbl_we !== (i < 3))
                $display("[TB] FAIL hold_drain[%0d] act=%h exp=%h", i, act_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_full_forced();
        int d0;
        d0 = m_drop;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(i < 6, rand_word(), 1'($urandom_range(0, 1)), rand_word(), i < 8, 1'b0);
            n_checks++;
            if ({act_vec, pred_block} !== {exp_vec, exp_block})
                $display("[TB] FAIL forced[%0d] act=%h/%b exp=%h/%b", i, act_vec, pred_block, exp_vec, exp_block);
            else n_pass++;
            if (i == 4 || i == 5 || i == 6) begin
                n_checks++;
                if ({tbl_we, pred_block} !== 2'b11) $display("[TB] FAIL forced_steal[%0d] act=%b exp=11", i, {tbl_we, pred_block});
                else n_pass++;
            end
        end
        n_checks++;
        if (drop_cnt !== 16'(d0)) $display("[TB] FAIL forced_nodrop act=%0d exp=%0d", drop_cnt, d0);
        else n_pass++;
    endtask

    task automatic test_init_drops();
        int d0;
        d0 = m_drop;
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < ENTRIES; i++) begin
            apply_stimulus(i < 5, rand_word(), 1'b1, rand_word(), 1'($urandom_range(0, 1)), 1'b0);
            n_checks++;
            if (act_vec !== exp_vec) $display("[TB] FAIL drop_sweep[%0d] act=%h exp=%h", i, act_vec, exp_vec);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            n_checks++;
            if ({tbl_we, drop_cnt} !== {1'b0, 16'(d0 + 5)})
                $display("[TB] FAIL init_drops[%0d] we=%b drop=%0d exp_drop=%0d", i, tbl_we, drop_cnt, d0 + 5);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        apply_stimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b1, 1'b0);
        apply_stimulus(1'b1, rand_word(), 1'b1, rand_word(), 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (tbl_we !== 1'b0) $display("[TB] FAIL flush_cycle act=%b exp=0", tbl_we);
        else n_pass++;
        for (int i = 0; i < ENTRIES + 3; i++) begin
            apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            n_checks++;
            if (i == 0 && {tbl_we, tbl_idx, tbl_valid} !== {1'b1, 6'd0, 1'b0})
                $display("[TB] FAIL flush_restart act=%b exp=1_000000_0", {tbl_we, tbl_idx, tbl_valid});
            else if (i >= ENTRIES && tbl_we !== 1'b0)
                $display("[TB] FAIL flush_discard[%0d] act=%b exp=0", i, tbl_we);
            else n_pass++;
        end
    endtask

    task automatic test_flush_during_sweep();
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (tbl_we !== 1'b0) $display("[TB] FAIL sweep_flush act=%b exp=0", tbl_we);
        else n_pass++;
        for (int i = 0; i <= ENTRIES; i++) begin
            apply_stimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            n_checks++;
            if (act_vec !== exp_vec || init_busy !== (i < ENTRIES) || (i < ENTRIES && tbl_idx !== 6'(i)))
                $display("[TB] FAIL sweep_restart[%0d] act=%h busy=%b exp=%h", i, act_vec, init_busy, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 99) < 60, rand_word(), 1'($urandom_range(0, 1)), rand_word(),
                           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
            n_checks++;
            if ({act_vec, init_busy, pred_block, drop_cnt} !== {exp_vec, exp_busy, exp_block, 16'(exp_drop)})
                $display("[TB] FAIL random[%0d] act=%h/%b%b/%0d exp=%h/%b%b/%0d", i, act_vec, init_busy,
                         pred_block, drop_cnt, exp_vec, exp_busy, exp_block, exp_drop);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_single_update();
        test_lookup_hold();
        test_full_forced();
        test_init_drops();
        test_flush();
        test_flush_during_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
